// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a requesting unit and serial_add_ctrl.
// The sub line exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADD_SUB_EN
  modport master (output start, a, b, sub, input ready, busy, done, sum, cout);
  modport slave  (input start, a, b, sub, output ready, busy, done, sum, cout);
`else
  modport master (output start, a, b, input ready, busy, done, sum, cout);
  modport slave  (input start, a, b, output ready, busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one half-adder pair plus a carry flop, LSB first.
// Optional subtract mode (port sub) is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  serial_add_ctrl_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_b_in;
  logic             w_cin0;
  logic [1:0]       w_ha1;
  logic [1:0]       w_ha2;
  logic             w_bit;
  logic             w_carry_nxt;
  logic             w_last;

  // Returns {carry, sum} of a single half adder.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    half_add = {x & y, x ^ y};
  endfunction

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction is a + ~b + 1, so invert B and seed the carry.
  assign w_b_in = bus.sub ? ~bus.b : bus.b;
  assign w_cin0 = bus.sub;
`else
  assign w_b_in = bus.b;
  assign w_cin0 = 1'b0;
`endif

  assign w_ha1       = half_add(r_a_sh[0], r_b_sh[0]);
  assign w_ha2       = half_add(w_ha1[0], r_carry);
  assign w_bit       = w_ha2[0];
  assign w_carry_nxt = w_ha1[1] | w_ha2[1];
  assign w_last      = (r_cnt == CW'(WIDTH - 1));

  assign bus.ready = r_ready;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.sum   = r_sum;
  assign bus.cout  = r_cout;

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_nxt = S_RUN;
        else           w_state_nxt = S_IDLE;
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_DONE;
        else        w_state_nxt = S_RUN;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register with status flags registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == S_IDLE);
      r_busy  <= (w_state_nxt == S_RUN);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  // Operand capture and one result bit per RUN cycle; cnt holds at WIDTH-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a_sh  <= bus.a;
            r_b_sh  <= w_b_in;
            r_carry <= w_cin0;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_sum   <= {w_bit, r_sum[WIDTH-1:1]};
          r_carry <= w_carry_nxt;
          r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
          if (w_last) r_cout <= w_carry_nxt;
          else        r_cnt  <= r_cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8); covers both builds.
module tb_serial_add_ctrl;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  vec_t vecs[$];

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain arithmetic, {cout,sum} = a+b, or a-b with cout = no borrow.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic sub);
    int unsigned ia;
    int unsigned ib;
    int unsigned r;
    ia = a;
    ib = b;
    if (sub) begin
      r = (ia + 256 - ib) % 256;
      model = {(ia >= ib) ? 1'b1 : 1'b0, r[W-1:0]};
    end else begin
      r = ia + ib;
      model = r[W:0];
    end
  endfunction

  task automatic set_ops(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    bus.a = a;
    bus.b = b;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub = sub;
`else
    if (sub) $display("note: subtract requested in add-only build");
`endif
  endtask

  // One operation; poke>=0 pulses start with other operands at that RUN cycle.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input int poke, input string nm);
    int wait_cnt;
    int lat;
    int busy_cnt;
    logic [W:0] exp;
    exp = model(a, b, sub);
    wait_cnt = 0;
    while (!bus.ready && wait_cnt < 30) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    chk({nm, "_ready"}, 32'(bus.ready), 32'd1);
    set_ops(a, b, sub);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    set_ops(W'($urandom), W'($urandom), sub);
    lat = 0;
    busy_cnt = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) busy_cnt++;
      if (lat == poke) begin
        set_ops(8'hFF, 8'hFF, 1'b0);
        bus.start = 1'b1;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'd8);
    chk({nm, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
    chk({nm, "_sum"}, 32'(bus.sum), 32'(exp[W-1:0]));
    chk({nm, "_cout"}, 32'(bus.cout), 32'(exp[W]));
    chk({nm, "_ready_in_done"}, 32'(bus.ready), 32'd0);
    @(posedge clk); #1;
    chk({nm, "_done_one_cycle"}, 32'(bus.done), 32'd0);
    chk({nm, "_ready_after"}, 32'(bus.ready), 32'd1);
    chk({nm, "_sum_hold"}, 32'(bus.sum), 32'(exp[W-1:0]));
  endtask

  initial begin
    int done_idx[$];
    int no_done;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rs;
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    set_ops('0, '0, 1'b0);

    vecs.push_back('{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1});
    vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0});
`ifdef SERIAL_ADD_SUB_EN
    vecs.push_back('{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1});
    vecs.push_back('{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0});
    vecs.push_back('{8'h55, 8'h55, 1'b1, 8'h00, 1'b1});
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_sum", 32'(bus.sum), 32'd0);
    chk("reset_cout", 32'(bus.cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_ready", 32'(bus.ready), 32'd1);

    // Table-driven directed vectors; expectations are literal constants.
    for (int i = 0; i < vecs.size(); i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].sub, -1, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_const_sum", i), 32'(bus.sum), 32'(vecs[i].exp_sum));
      chk($sformatf("vec%0d_const_cout", i), 32'(bus.cout), 32'(vecs[i].exp_cout));
    end

    // start pulse at RUN cycle 3 must be ignored.
    do_op(8'h3C, 8'h0F, 1'b0, 3, "ignore_start");

    // start held high: one accepted op every 10 cycles.
    set_ops(8'h11, 8'h22, 1'b0);
    bus.start = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (bus.done) begin
        done_idx.push_back(i);
        chk("held_sum", 32'(bus.sum), 32'h33);
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    chk("held_done_count", 32'(done_idx.size()), 32'd3);
    for (int i = 1; i < done_idx.size(); i++)
      chk("held_period", 32'(done_idx[i] - done_idx[i-1]), 32'd10);

    // Reset in the middle of RUN.
    do_op(8'hFF, 8'hFF, 1'b0, -1, "pre_reset");
    set_ops(8'h3C, 8'h0F, 1'b0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_sum", 32'(bus.sum), 32'd0);
    chk("midrst_cout", 32'(bus.cout), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    no_done = 1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.done) no_done = 0;
    end
    chk("midrst_no_done", 32'(no_done), 32'd1);
    do_op(8'h3C, 8'h0F, 1'b0, -1, "post_reset");

    // Random operations against the arithmetic model.
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom_range(1, 0));
`else
      rs = 1'b0;
`endif
      do_op(ra, rb, rs, -1, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
